// File: rtl/serial_subtractor_32b_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_32b_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_32b_full_subtractor_1b.sv
// One-bit full subtractor: the single arithmetic cell of the serial datapath.
module full_subtractor_1b (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_32b.sv
// Bit-serial a - b, LSB first, one bit per clock, with borrow/overflow/zero/negative flags.
module serial_subtractor_32b
    import serial_subtractor_32b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]   res_reg, res_next;
    logic               bin_reg, bin_next;
    logic               nz_reg, nz_next;
    logic               a_msb_reg, a_msb_next;
    logic               b_msb_reg, b_msb_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic               borrow_reg, borrow_next;
    logic               overflow_reg, overflow_next;
    logic               zero_reg, zero_next;
    logic               negative_reg, negative_next;

    logic               d_bit;
    logic               bout;
    logic [WIDTH-1:0]   a_shift, b_shift, res_shift;

    full_subtractor_1b u_cell (
        .diff (d_bit),
        .bout (bout),
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bin_reg)
    );

    // Operands move toward the LSB; the result fills from the MSB side so
    // after WIDTH shifts bit 0 has landed in position 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi]   = a_sh_reg[gi+1];
            assign b_shift[gi]   = b_sh_reg[gi+1];
            assign res_shift[gi] = res_reg[gi+1];
        end
    endgenerate
    assign a_shift[WIDTH-1]   = 1'b0;
    assign b_shift[WIDTH-1]   = 1'b0;
    assign res_shift[WIDTH-1] = d_bit;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        a_sh_next     = a_sh_reg;
        b_sh_next     = b_sh_reg;
        res_next      = res_reg;
        bin_next      = bin_reg;
        nz_next       = nz_reg;
        a_msb_next    = a_msb_reg;
        b_msb_next    = b_msb_reg;
        diff_next     = diff_reg;
        borrow_next   = borrow_reg;
        overflow_next = overflow_reg;
        zero_next     = zero_reg;
        negative_next = negative_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                    a_sh_next  = a;
                    b_sh_next  = b;
                    res_next   = '0;
                    bin_next   = 1'b0;
                    nz_next    = 1'b0;
                    a_msb_next = a[WIDTH-1];
                    b_msb_next = b[WIDTH-1];
                end
            end
            ST_RUN: begin
                a_sh_next = a_shift;
                b_sh_next = b_shift;
                res_next  = res_shift;
                bin_next  = bout;
                nz_next   = nz_reg | d_bit;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // Last bit: publish results from the values being formed this edge.
                    state_next    = ST_DONE;
                    diff_next     = res_shift;
                    borrow_next   = bout;
                    overflow_next = (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
                    zero_next     = ~(nz_reg | d_bit);
                    negative_next = d_bit;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            res_reg      <= '0;
            bin_reg      <= 1'b0;
            nz_reg       <= 1'b0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            a_sh_reg     <= a_sh_next;
            b_sh_reg     <= b_sh_next;
            res_reg      <= res_next;
            bin_reg      <= bin_next;
            nz_reg       <= nz_next;
            a_msb_reg    <= a_msb_next;
            b_msb_reg    <= b_msb_next;
            diff_reg     <= diff_next;
            borrow_reg   <= borrow_next;
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
            negative_reg <= negative_next;
        end
    end

    assign ready    = (state_reg == ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;
    assign negative = negative_reg;

endmodule

// File: tb/tb_serial_subtractor_32b.sv
// Self-checking bench: directed vector table, handshake corner cases and random ops vs arithmetic model.
module tb_serial_subtractor_32b;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        ready, done;
    logic [31:0] diff;
    logic        borrow, overflow, zero, negative;

    int checks = 0;
    int errors = 0;

    serial_subtractor_32b dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        bit          bo;
        bit          ov;
        bit          z;
        bit          n;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the operands.
    task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] d,
                         output bit bo, output bit ov, output bit z, output bit n);
        longint sd;
        sd = longint'(int'(x)) - longint'(int'(y));
        d  = x - y;
        bo = (x < y);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        z  = (d == 32'd0);
        n  = d[31];
    endtask

    // Starts an op at a negedge, waits for done and checks latency, results and hold behaviour.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] ed,
                         input bit eb, input bit eo, input bit ez, input bit en);
        int        lat;
        bit        changed;
        logic [35:0] prev;
        int        w;
        w = 0;
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_start", ready, 1);
        prev  = {diff, borrow, overflow, zero, negative};
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start = 1'b0;
        chk("ready_fall", ready, 0);
        lat = 0;
        changed = 0;
        while (!done && lat < 100) begin
            if ({diff, borrow, overflow, zero, negative} !== prev) changed = 1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 32);
        chk("hold_until_done", changed, 0);
        chk("diff", diff, ed);
        chk("flags", {borrow, overflow, zero, negative}, {eb, eo, ez, en});
        $display("op a=%08h b=%08h diff=%08h bo=%0b ov=%0b z=%0b n=%0b lat=%0d",
                 ta, tb_, diff, borrow, overflow, zero, negative, lat);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("ready_rise", ready, 1);
    endtask

    initial begin
        logic [31:0] md;
        bit          mbo, mov, mz, mn;
        int          low_cnt, done_cnt;
        logic [31:0] seen_diff;

        vecs[0] = '{32'd5,        32'd3,        32'h00000002, 0, 0, 0, 0};
        vecs[1] = '{32'd3,        32'd5,        32'hFFFFFFFE, 1, 0, 0, 1};
        vecs[2] = '{32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 1, 0, 0};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0, 1};
        vecs[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 0, 0, 1, 0};
        vecs[5] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0, 0, 1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_outputs", {diff, borrow, overflow, zero, negative}, 36'd0);

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z, vecs[i].n);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        low_cnt = 0; done_cnt = 0; seen_diff = '0;
        for (int j = 0; j < 40; j++) begin
            if (!ready) low_cnt++;
            if (done) begin
                done_cnt++;
                seen_diff = diff;
            end
            if (j == 5) begin start = 1'b1; a = 32'd100; b = 32'd1; end
            if (j == 6) start = 1'b0;
            @(negedge clk);
        end
        chk("busy_ready_low_cycles", low_cnt, 33);
        chk("busy_done_count", done_cnt, 1);
        chk("busy_diff", seen_diff, 32'd5);
        $display("op a=9 b=4 with ignored start: diff=%08h dones=%0d ready_low=%0d", seen_diff, done_cnt, low_cnt);

        // reset while processing bit 10
        start = 1'b1; a = 32'h12345678; b = 32'h00000042;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_outputs", {diff, borrow, overflow, zero, negative}, 36'd0);
        done_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_outputs_later", {diff, borrow, overflow, zero, negative}, 36'd0);
        $display("op aborted by reset: dones=%0d", done_cnt);
        do_op(32'd7, 32'd7, 32'd0, 0, 0, 1, 0);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            if (i % 5 == 1) ra[31] = ~rb[31];
            model(ra, rb, md, mbo, mov, mz, mn);
            do_op(ra, rb, md, mbo, mov, mz, mn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
